id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the datapath width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have input ports id_valid (1), id_rs (5), id_rt (5), id_rd (5), id_rs_data (DATA_W), id_rt_data (DATA_W), id_imm (DATA_W, already sign-extended): the decode-stage instruction.
REQ-005 The block SHALL have input ports id_alu_op (2), id_funct (6), id_alu_src (1: 1 selects imm for b), id_reg_dst (1: 1 selects rd, else rt), id_reg_write (1): decode control.
REQ-006 The block SHALL have input ports stall (1: hold contents) and flush (1: insert bubble).
REQ-007 The block SHALL have input ports exm_reg_write (1), exm_rd (5), exm_result (DATA_W): EX/MEM forwarding source.
REQ-008 The block SHALL have input ports wb_reg_write (1), wb_rd (5), wb_data (DATA_W): MEM/WB forwarding and register-file write source.
REQ-009 The block SHALL have output ports a (DATA_W), b (DATA_W), Alu_op (2), funct (6): direct feed of the ALU operand and control inputs.
REQ-010 The block SHALL have output ports ex_valid (1), ex_dest (5), ex_reg_write (1), ex_store_data (DATA_W): forwarded rt value for stores.

Function
REQ-011 The block SHALL register all id_* inputs in one pipeline stage: inputs sampled at edge N appear on outputs after edge N (latency 1 cycle).
REQ-012 The block SHALL load new contents on each edge when stall=0 and flush=0.
REQ-013 The block SHALL, when flush=1 (priority over stall), load a bubble: ex_valid=0, ex_reg_write=0, Alu_op=2'b00, funct=0, ex_dest=0, stored data/imm/rs/rt zeroed.
REQ-014 The block SHALL load a bubble (as REQ-013) when id_valid=0 and stall=0.
REQ-015 The block SHALL, when stall=1 and flush=0, hold all stored fields unchanged except per REQ-016.
REQ-016 The block SHALL, during a stall, overwrite the stored rs_data (rt_data) with wb_data when wb_reg_write=1, wb_rd equals stored rs (rt), and wb_rd!=0, so held operands never go stale.
REQ-017 The block SHALL store ex_dest = id_reg_dst ? id_rd : id_rt at load time.
REQ-018 The block SHALL compute forwarded rs operand combinationally: exm_result if exm_reg_write=1, exm_rd!=0, exm_rd==stored rs; else wb_data if wb_reg_write=1, wb_rd!=0, wb_rd==stored rs; else stored rs_data.
REQ-019 The block SHALL compute the forwarded rt operand with the same priority (EX/MEM over MEM/WB) against stored rt.
REQ-020 The block SHALL drive a = forwarded rs; b = stored alu_src ? stored imm : forwarded rt; ex_store_data = forwarded rt always.
REQ-021 The block SHALL never forward to register 0: a source index of 0 yields the stored value (zero from the register file).
REQ-022 The block SHALL suppress forwarding when ex_valid=0 (a and b then equal stored zeroed values).
REQ-023 The block SHALL pass Alu_op and funct unmodified; widths are exact, no truncation or extension of any field.

Reset
REQ-024 The block SHALL, when reset=1 at an edge, load a bubble regardless of stall/flush/id_valid: ex_valid=0, ex_reg_write=0, ex_dest=0, Alu_op=0, funct=0, a=0, b=0, ex_store_data=0.
REQ-025 The block SHALL discard any held (stalled) instruction when reset is asserted mid-stall; first load after reset release follows REQ-012.

Verification
REQ-026 Load: id_valid=1, rs=1 data=30, rt=2 data=30, alu_src=0, Alu_op=2, funct=100010 -> next cycle a=30, b=30, Alu_op=2, funct=100010, ex_valid=1.
REQ-027 Forward priority: stored rs=3, exm_rd=3 result=45, wb_rd=3 data=46, both reg_write=1 -> a=45; drop exm_reg_write -> a=46; exm_rd=0 with rs=0 -> a=0.
REQ-028 Immediate: alu_src=1, imm=0xFFFFFFFE, rt=5 forwarded from exm=20 -> b=0xFFFFFFFE, ex_store_data=20; reg_dst=1, rd=7, rt=5 -> ex_dest=7.
REQ-029 Stall refresh: hold instruction rs=4 data=10 with stall=1, wb_rd=4 data=99 for one cycle, then wb idle -> a=99 while still stalled; outputs otherwise unchanged.
REQ-030 Flush vs stall: stall=1 and flush=1 same edge -> bubble (ex_valid=0, Alu_op=0, ex_reg_write=0); id_valid=0 without stall -> bubble.
REQ-031 Reset mid-stall: valid instruction held, reset=1 one edge -> all outputs zero, ex_valid=0; release with id_valid=1 -> loads new instruction next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding; 1-cycle latency.
// stall holds contents (held operands refreshed from WB); flush or id_valid=0 loads a bubble.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              stall,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [4:0]        exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [1:0]        Alu_op,
  output logic [5:0]        funct,
  output logic              ex_valid,
  output logic [4:0]        ex_dest,
  output logic              ex_reg_write,
  output logic [DATA_W-1:0] ex_store_data
);

  logic              r_valid;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_dest;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [1:0]        r_alu_op;
  logic [5:0]        r_funct;
  logic              r_alu_src;
  logic              r_reg_write;

  logic              w_bubble;
  logic              w_exm_rs_hit;
  logic              w_exm_rt_hit;
  logic              w_wb_rs_hit;
  logic              w_wb_rt_hit;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  assign w_bubble = reset || flush || (!stall && !id_valid);

  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_valid     <= 1'b0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_dest      <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_alu_op    <= '0;
      r_funct     <= '0;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (!stall) begin
      r_valid     <= 1'b1;
      r_rs        <= id_rs;
      r_rt        <= id_rt;
      r_dest      <= id_reg_dst ? id_rd : id_rt;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_imm       <= id_imm;
      r_alu_op    <= id_alu_op;
      r_funct     <= id_funct;
      r_alu_src   <= id_alu_src;
      r_reg_write <= id_reg_write;
    end else begin
      // Held instruction absorbs register-file writes so its operands stay current.
      if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rs)) r_rs_data <= wb_data;
      if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rt)) r_rt_data <= wb_data;
    end
  end

  assign w_exm_rs_hit = r_valid && exm_reg_write && (exm_rd != 5'd0) && (exm_rd == r_rs);
  assign w_exm_rt_hit = r_valid && exm_reg_write && (exm_rd != 5'd0) && (exm_rd == r_rt);
  assign w_wb_rs_hit  = r_valid && wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == r_rs);
  assign w_wb_rt_hit  = r_valid && wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == r_rt);

  assign w_fwd_rs = w_exm_rs_hit ? exm_result : (w_wb_rs_hit ? wb_data : r_rs_data);
  assign w_fwd_rt = w_exm_rt_hit ? exm_result : (w_wb_rt_hit ? wb_data : r_rt_data);

  assign a             = w_fwd_rs;
  assign b             = r_alu_src ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign Alu_op        = r_alu_op;
  assign funct         = r_funct;
  assign ex_valid      = r_valid;
  assign ex_dest       = r_dest;
  assign ex_reg_write  = r_reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Vector-table bench for id_ex_stage: reset-state check, then one edge per row via a scoreboard queue.
// Latency: expected outputs sampled 1 time unit after the edge that loads each row.
// Backpressure: none; stall/flush are driven from the table, and a watchdog bounds total run time.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic        id_alu_src, id_reg_dst, id_reg_write;
    logic        stall, flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] a, b, ex_store_data;
    logic [1:0]  Alu_op;
    logic [5:0]  funct;
    logic        ex_valid, ex_reg_write;
    logic [4:0]  ex_dest;

    id_ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .stall(stall), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .a(a), .b(b), .Alu_op(Alu_op), .funct(funct),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        vld;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        stall;
        logic        flush;
        logic        exm_rw;
        logic [4:0]  exm_rd;
        logic [31:0] exm_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } in_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        valid;
        logic [4:0]  dest;
        logic        rw;
        logic [31:0] sd;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    exp_t sb [$];
    exp_t exp_v, act_v;
    int   n_cmp = 0;
    int   n_mis = 0;
    logic done = 1'b0;

    task automatic drive(input in_t v);
        reset         = v.rst;
        id_valid      = v.vld;
        id_rs         = v.rs;
        id_rt         = v.rt;
        id_rd         = v.rd;
        id_rs_data    = v.rs_data;
        id_rt_data    = v.rt_data;
        id_imm        = v.imm;
        id_alu_op     = v.alu_op;
        id_funct      = v.funct;
        id_alu_src    = v.alu_src;
        id_reg_dst    = v.reg_dst;
        id_reg_write  = v.reg_write;
        stall         = v.stall;
        flush         = v.flush;
        exm_reg_write = v.exm_rw;
        exm_rd        = v.exm_rd;
        exm_result    = v.exm_res;
        wb_reg_write  = v.wb_rw;
        wb_rd         = v.wb_rd;
        wb_data       = v.wb_data;
    endtask

    initial begin
        #5000;
        n_cmp++;
        if (!done) begin
            n_mis++;
            $display("FAIL timeout: only %0d comparisons completed before watchdog expired", n_cmp - 1);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
            $finish;
        end
    end

    initial begin
        // in: rst vld rs rt rd rs_data rt_data imm op funct src dst rw stall flush exm_rw exm_rd exm_res wb_rw wb_rd wb_data
        // exp: a b op funct valid dest rw store_data
        vecs[0]  = '{'{1'b1,1'b0,5'd0,5'd0,5'd0,32'd0,32'd0,32'd0,2'd0,6'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'd0,32'd0,2'd0,6'h00,1'b0,5'd0,1'b0,32'd0}};
        vecs[1]  = '{'{1'b0,1'b1,5'd1,5'd2,5'd0,32'd30,32'd30,32'd0,2'd2,6'b100010,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'd30,32'd30,2'd2,6'b100010,1'b1,5'd2,1'b1,32'd30}};
        vecs[2]  = '{'{1'b0,1'b1,5'd3,5'd6,5'd8,32'd5,32'd7,32'd0,2'd0,6'h20,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,5'd3,32'd45,1'b1,5'd3,32'd46},
                     '{32'd45,32'd7,2'd0,6'h20,1'b1,5'd8,1'b1,32'd7}};
        vecs[3]  = '{'{1'b0,1'b1,5'd9,5'd9,5'd9,32'd1,32'd1,32'd1,2'd3,6'h3F,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd3,32'd45,1'b1,5'd3,32'd46},
                     '{32'd46,32'd7,2'd0,6'h20,1'b1,5'd8,1'b1,32'd7}};
        vecs[4]  = '{'{1'b0,1'b1,5'd9,5'd9,5'd9,32'd1,32'd1,32'd1,2'd3,6'h3F,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'd46,32'd7,2'd0,6'h20,1'b1,5'd8,1'b1,32'd7}};
        vecs[5]  = '{'{1'b0,1'b1,5'd0,5'd0,5'd0,32'd0,32'd0,32'd0,2'd1,6'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd0,32'd45,1'b1,5'd0,32'd46},
                     '{32'd0,32'd0,2'd1,6'h00,1'b1,5'd0,1'b0,32'd0}};
        vecs[6]  = '{'{1'b0,1'b1,5'd1,5'd5,5'd7,32'd11,32'd3,32'hFFFFFFFE,2'd0,6'h23,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,5'd5,32'd20,1'b0,5'd0,32'd0},
                     '{32'd11,32'hFFFFFFFE,2'd0,6'h23,1'b1,5'd7,1'b1,32'd20}};
        vecs[7]  = '{'{1'b0,1'b1,5'd1,5'd5,5'd7,32'd11,32'd3,32'hFFFFFFFE,2'd0,6'h23,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd5,32'd20,1'b0,5'd0,32'd0},
                     '{32'd11,32'hFFFFFFFE,2'd0,6'h23,1'b1,5'd7,1'b1,32'd3}};
        vecs[8]  = '{'{1'b0,1'b1,5'd4,5'd0,5'd12,32'd10,32'd0,32'd0,2'd2,6'h20,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'd10,32'd0,2'd2,6'h20,1'b1,5'd12,1'b1,32'd0}};
        vecs[9]  = '{'{1'b0,1'b1,5'd9,5'd9,5'd9,32'd1,32'd1,32'd1,2'd3,6'h3F,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0,32'd0,1'b1,5'd4,32'd99},
                     '{32'd99,32'd0,2'd2,6'h20,1'b1,5'd12,1'b1,32'd0}};
        vecs[10] = '{'{1'b0,1'b1,5'd9,5'd9,5'd9,32'd1,32'd1,32'd1,2'd3,6'h3F,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'd99,32'd0,2'd2,6'h20,1'b1,5'd12,1'b1,32'd0}};
        vecs[11] = '{'{1'b0,1'b1,5'd9,5'd9,5'd9,32'd1,32'd1,32'd1,2'd3,6'h3F,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,5'd4,32'd77,1'b1,5'd4,32'd5},
                     '{32'd77,32'd0,2'd2,6'h20,1'b1,5'd12,1'b1,32'd0}};
        vecs[12] = '{'{1'b0,1'b1,5'd9,5'd9,5'd9,32'd1,32'd1,32'd1,2'd3,6'h3F,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'd5,32'd0,2'd2,6'h20,1'b1,5'd12,1'b1,32'd0}};
        vecs[13] = '{'{1'b0,1'b1,5'd4,5'd0,5'd12,32'd10,32'd0,32'd0,2'd2,6'h20,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,5'd0,32'd45,1'b0,5'd0,32'd0},
                     '{32'd0,32'd0,2'd0,6'h00,1'b0,5'd0,1'b0,32'd0}};
        vecs[14] = '{'{1'b0,1'b1,5'd1,5'd2,5'd0,32'd1,32'd2,32'd0,2'd1,6'h21,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'd1,32'd2,2'd1,6'h21,1'b1,5'd2,1'b1,32'd2}};
        vecs[15] = '{'{1'b0,1'b0,5'd1,5'd2,5'd3,32'd1,32'd2,32'd4,2'd1,6'h21,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'd0,32'd0,2'd0,6'h00,1'b0,5'd0,1'b0,32'd0}};
        vecs[16] = '{'{1'b0,1'b1,5'd2,5'd3,5'd0,32'd8,32'd9,32'd0,2'd3,6'h3F,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'd8,32'd9,2'd3,6'h3F,1'b1,5'd3,1'b1,32'd9}};
        vecs[17] = '{'{1'b0,1'b1,5'd9,5'd9,5'd9,32'd1,32'd1,32'd1,2'd1,6'h01,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'd8,32'd9,2'd3,6'h3F,1'b1,5'd3,1'b1,32'd9}};
        vecs[18] = '{'{1'b1,1'b1,5'd9,5'd9,5'd9,32'd1,32'd1,32'd1,2'd1,6'h01,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'd0,32'd0,2'd0,6'h00,1'b0,5'd0,1'b0,32'd0}};
        vecs[19] = '{'{1'b0,1'b1,5'd6,5'd7,5'd1,32'hDEADBEEF,32'h12345678,32'd0,2'd1,6'h2A,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'd0,1'b0,5'd0,32'd0},
                     '{32'hDEADBEEF,32'h12345678,2'd1,6'h2A,1'b1,5'd1,1'b1,32'h12345678}};
        vecs[20] = '{'{1'b0,1'b1,5'd2,5'd9,5'd0,32'd1,32'd2,32'd0,2'd0,6'h00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,5'd2,32'h66,1'b1,5'd9,32'h55},
                     '{32'h66,32'h55,2'd0,6'h00,1'b1,5'd9,1'b0,32'h55}};

        drive('0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({a, b, Alu_op, funct, ex_valid, ex_dest, ex_reg_write, ex_store_data} !== '0) begin
            n_mis++;
            $display("FAIL reset: a=%h b=%h op=%h funct=%h vld=%b dest=%0d rw=%b sd=%h",
                     a, b, Alu_op, funct, ex_valid, ex_dest, ex_reg_write, ex_store_data);
        end

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(vecs[k].i);
            sb.push_back(vecs[k].e);
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            act_v = '{a, b, Alu_op, funct, ex_valid, ex_dest, ex_reg_write, ex_store_data};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_mis++;
                $display("FAIL vec%0d: got a=%h b=%h op=%h funct=%h vld=%b dest=%0d rw=%b sd=%h ; want a=%h b=%h op=%h funct=%h vld=%b dest=%0d rw=%b sd=%h",
                         k, act_v.a, act_v.b, act_v.op, act_v.funct, act_v.valid, act_v.dest, act_v.rw, act_v.sd,
                         exp_v.a, exp_v.b, exp_v.op, exp_v.funct, exp_v.valid, exp_v.dest, exp_v.rw, exp_v.sd);
            end
        end

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
